// File: rtl/mw_power_sequencer.sv
// Microwave cook-cycle sequencer: front-panel edge detection, IDLE/POWER_SET/COOK/PAUSE/DONE
// control, 1 Hz prescaler, power-level duty cycling of the magnetron and end-of-cook beep.
module mw_power_sequencer #(
  parameter int unsigned CLK_HZ    = 100,
  parameter int unsigned BEEP_SECS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] keypad,
  input  logic       powern,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic       sec_tick,
  output logic       timer_run,
  output logic       mag_on,
  output logic [3:0] power_level,
  output logic       beep,
  output logic       busy
);

  localparam int unsigned PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned BEEP_W  = (BEEP_SECS > 0) ? $clog2(BEEP_SECS + 1) : 1;
  localparam int unsigned WIN_W   = 4;
  localparam int unsigned PWR_W   = 4;
  localparam int unsigned KEY_W   = 10;

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);
  localparam logic [BEEP_W-1:0]  BEEP_LAST = BEEP_W'(BEEP_SECS - 1);
  localparam logic [WIN_W-1:0]   WIN_MAX   = WIN_W'(9);
  localparam logic [PWR_W-1:0]   PWR_FULL  = PWR_W'(10);

  typedef enum logic [2:0] {
    S_IDLE, S_POWER_SET, S_COOK, S_PAUSE, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [BEEP_W-1:0]  beep_cnt_q, beep_cnt_d;
  logic [PWR_W-1:0]   power_q, power_d;
  logic               powern_q, startn_q, stopn_q;
  logic [KEY_W-1:0]   keypad_q;
  logic               sec_tick_q, sec_tick_d;
  logic               timer_run_q, timer_run_d;
  logic               mag_q, mag_d;
  logic               beep_q, beep_d;
  logic               busy_q, busy_d;

  logic               power_ev, start_ev, stop_ev, key_ev, presc_wrap;
  logic [PWR_W-1:0]   key_digit, key_level;

  // Button events are falling edges against the registered history.
  assign power_ev   = powern_q & ~powern;
  assign start_ev   = startn_q & ~startn;
  assign stop_ev    = stopn_q & ~stopn;
  assign key_ev     = (keypad_q == '0) && (keypad != '0) &&
                      ((keypad & (keypad - KEY_W'(1))) == '0);
  assign presc_wrap = (presc_q == PRESC_MAX);

  always_comb begin
    key_digit = '0;
    for (int i = 0; i < KEY_W; i++) begin
      if (keypad[i]) key_digit = PWR_W'(i);
    end
    key_level = (key_digit == '0) ? PWR_FULL : key_digit;
  end

  always_comb begin
    state_d = state_q;
    power_d = power_q;
    case (state_q)
      S_IDLE: begin
        if (power_ev) state_d = S_POWER_SET;
        else if (start_ev && !stop_ev && door_closed && !timer_zero) state_d = S_COOK;
      end
      S_POWER_SET: begin
        if (stop_ev) state_d = S_IDLE;
        else if (key_ev) begin
          power_d = key_level;
          state_d = S_IDLE;
        end
      end
      S_COOK: begin
        if (timer_zero) state_d = S_DONE;
        else if (!door_closed || stop_ev) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (stop_ev) state_d = S_IDLE;
        else if (start_ev && door_closed) state_d = S_COOK;
      end
      S_DONE: begin
        if (start_ev || stop_ev) state_d = S_IDLE;
        else if (presc_wrap && (beep_cnt_q == BEEP_LAST)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The prescaler still advances on the cycle COOK is left, so a held count never re-ticks.
    presc_d    = presc_q;
    win_d      = win_q;
    beep_cnt_d = beep_cnt_q;
    if ((state_q == S_COOK) || (state_q == S_DONE))
      presc_d = presc_wrap ? '0 : presc_q + PRESC_W'(1);
    if ((state_q == S_COOK) && presc_wrap)
      win_d = (win_q == WIN_MAX) ? '0 : win_q + WIN_W'(1);
    if ((state_q == S_DONE) && presc_wrap)
      beep_cnt_d = beep_cnt_q + BEEP_W'(1);
    if (state_d == S_IDLE) begin
      presc_d = '0;
      win_d   = '0;
    end
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      presc_d    = '0;
      beep_cnt_d = '0;
    end

    sec_tick_d  = (state_d == S_COOK) && (presc_d == PRESC_MAX);
    timer_run_d = (state_d == S_COOK);
    busy_d      = (state_d == S_COOK) || (state_d == S_PAUSE) || (state_d == S_DONE);
    beep_d      = (state_d == S_DONE);
    mag_d       = (state_d == S_COOK) && (win_d < power_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      win_q       <= '0;
      beep_cnt_q  <= '0;
      power_q     <= PWR_FULL;
      powern_q    <= 1'b1;
      startn_q    <= 1'b1;
      stopn_q     <= 1'b1;
      keypad_q    <= '0;
      sec_tick_q  <= 1'b0;
      timer_run_q <= 1'b0;
      mag_q       <= 1'b0;
      beep_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      win_q       <= win_d;
      beep_cnt_q  <= beep_cnt_d;
      power_q     <= power_d;
      powern_q    <= powern;
      startn_q    <= startn;
      stopn_q     <= stopn;
      keypad_q    <= keypad;
      sec_tick_q  <= sec_tick_d;
      timer_run_q <= timer_run_d;
      mag_q       <= mag_d;
      beep_q      <= beep_d;
      busy_q      <= busy_d;
    end
  end

  // Door interlock is combinational so opening the door kills the magnetron immediately.
  assign mag_on      = mag_q & door_closed;
  assign sec_tick    = sec_tick_q;
  assign timer_run   = timer_run_q;
  assign power_level = power_q;
  assign beep        = beep_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mw_power_sequencer.sv
// Directed self-checking bench for mw_power_sequencer at CLK_HZ=100, BEEP_SECS=3.
module tb_mw_power_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] keypad;
  logic       powern, startn, stopn, door_closed, timer_zero;
  logic       sec_tick, timer_run, mag_on, beep, busy;
  logic [3:0] power_level;

  int checks = 0;
  int errors = 0;

  mw_power_sequencer #(.CLK_HZ(100), .BEEP_SECS(3)) dut (
    .clk(clk), .rst(rst), .keypad(keypad), .powern(powern), .startn(startn),
    .stopn(stopn), .door_closed(door_closed), .timer_zero(timer_zero),
    .sec_tick(sec_tick), .timer_run(timer_run), .mag_on(mag_on),
    .power_level(power_level), .beep(beep), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    startn = 1'b0; cyc(); startn = 1'b1; cyc();
  endtask

  task automatic press_stop();
    stopn = 1'b0; cyc(); stopn = 1'b1; cyc();
  endtask

  task automatic press_power();
    powern = 1'b0; cyc(); powern = 1'b1; cyc();
  endtask

  task automatic press_key(input int d);
    keypad = '0; keypad[d] = 1'b1; cyc(); keypad = '0; cyc();
  endtask

  task automatic test_reset();
    int ticks, busy_seen, mag_seen;
    rst = 1'b1; keypad = '0; powern = 1'b1; startn = 1'b1; stopn = 1'b1;
    door_closed = 1'b1; timer_zero = 1'b0;
    repeat (3) cyc();
    checks++;
    if ({sec_tick, timer_run, mag_on, beep, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 00000", {sec_tick, timer_run, mag_on, beep, busy});
    end
    checks++;
    if (power_level !== 4'd10) begin
      errors++; $display("FAIL reset_power: got %0d expected 10", power_level);
    end
    rst = 1'b0;
    ticks = 0; busy_seen = 0; mag_seen = 0;
    repeat (500) begin
      cyc();
      if (sec_tick) ticks++;
      if (busy) busy_seen++;
      if (mag_on) mag_seen++;
    end
    checks++;
    if (ticks !== 0) begin errors++; $display("FAIL idle_ticks: got %0d expected 0", ticks); end
    checks++;
    if (busy_seen !== 0 || mag_seen !== 0) begin
      errors++; $display("FAIL idle_busy_mag: got busy=%0d mag=%0d expected 0 0", busy_seen, mag_seen);
    end
    checks++;
    if (power_level !== 4'd10) begin errors++; $display("FAIL idle_power: got %0d expected 10", power_level); end
  endtask

  task automatic test_power_cook();
    int ticks, tick_bad, mag_cnt, mag_bad;
    press_power();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL power_set_busy: got %b expected 0", busy); end
    press_key(3);
    checks++;
    if (power_level !== 4'd3) begin errors++; $display("FAIL power_3: got %0d expected 3", power_level); end
    ticks = 0; tick_bad = 0; mag_cnt = 0; mag_bad = 0;
    startn = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      cyc();
      startn = 1'b1;
      if (sec_tick) ticks++;
      if (sec_tick !== ((i % 100) == 99)) tick_bad++;
      if (mag_on) mag_cnt++;
      if (mag_on !== ((i % 1000) < 300)) mag_bad++;
    end
    checks++;
    if (ticks !== 20 || tick_bad !== 0) begin
      errors++; $display("FAIL cook_ticks: got %0d ticks %0d misplaced expected 20 0", ticks, tick_bad);
    end
    checks++;
    if (mag_cnt !== 600 || mag_bad !== 0) begin
      errors++; $display("FAIL cook_duty: got %0d on-cycles %0d misplaced expected 600 0", mag_cnt, mag_bad);
    end
    checks++;
    if (timer_run !== 1'b1) begin errors++; $display("FAIL cook_timer_run: got %b expected 1", timer_run); end
    press_stop();
    press_stop();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL cook_cancel_busy: got %b expected 0", busy); end
  endtask

  task automatic test_door_pause();
    int ticks, n;
    press_power();
    press_key(0);
    checks++;
    if (power_level !== 4'd10) begin errors++; $display("FAIL power_digit0: got %0d expected 10", power_level); end
    ticks = 0;
    startn = 1'b0;
    for (int i = 0; i < 250; i++) begin
      cyc();
      startn = 1'b1;
      if (sec_tick) ticks++;
    end
    checks++;
    if (ticks !== 2 || mag_on !== 1'b1) begin
      errors++; $display("FAIL door_precook: got ticks=%0d mag=%b expected 2 1", ticks, mag_on);
    end
    door_closed = 1'b0;
    #1;
    checks++;
    if (mag_on !== 1'b0) begin errors++; $display("FAIL door_interlock: got %b expected 0", mag_on); end
    cyc();
    checks++;
    if (timer_run !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL door_pause: got run=%b busy=%b expected 0 1", timer_run, busy);
    end
    ticks = 0;
    repeat (300) begin cyc(); if (sec_tick) ticks++; end
    checks++;
    if (ticks !== 0) begin errors++; $display("FAIL pause_ticks: got %0d expected 0", ticks); end
    door_closed = 1'b1;
    cyc();
    checks++;
    if (mag_on !== 1'b0) begin errors++; $display("FAIL pause_mag: got %b expected 0", mag_on); end
    n = 0;
    startn = 1'b0;
    while (n < 200) begin
      cyc();
      startn = 1'b1;
      n++;
      if (sec_tick) break;
    end
    checks++;
    if (n !== 50) begin errors++; $display("FAIL resume_tick_latency: got %0d expected 50", n); end
    press_stop();
    press_stop();
  endtask

  task automatic test_stop_cancel();
    int n;
    startn = 1'b0;
    for (int i = 0; i < 320; i++) begin cyc(); startn = 1'b1; end
    stopn = 1'b0;
    cyc();
    checks++;
    if (timer_run !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL stop_pause: got run=%b busy=%b expected 0 1", timer_run, busy);
    end
    stopn = 1'b1; cyc();
    stopn = 1'b0; cyc();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stop_cancel: got busy=%b expected 0", busy); end
    stopn = 1'b1; cyc();
    n = 0;
    startn = 1'b0;
    while (n < 200) begin
      cyc();
      startn = 1'b1;
      n++;
      if (sec_tick) break;
    end
    checks++;
    if (n !== 100) begin errors++; $display("FAIL restart_tick_latency: got %0d expected 100", n); end
    press_stop();
    press_stop();
  endtask

  task automatic test_done_beep();
    int n;
    startn = 1'b0;
    repeat (30) begin cyc(); startn = 1'b1; end
    timer_zero = 1'b1;
    cyc();
    checks++;
    if ({beep, mag_on, timer_run, busy} !== 4'b1001) begin
      errors++; $display("FAIL done_entry: got beep/mag/run/busy=%b expected 1001", {beep, mag_on, timer_run, busy});
    end
    n = 1;
    for (int k = 0; k < 400; k++) begin
      cyc();
      if (beep) n++;
      else break;
    end
    checks++;
    if (n !== 300) begin errors++; $display("FAIL beep_length: got %0d expected 300", n); end
    checks++;
    if (busy !== 1'b0 || beep !== 1'b0) begin
      errors++; $display("FAIL done_to_idle: got busy=%b beep=%b expected 0 0", busy, beep);
    end
    timer_zero = 1'b0;
    startn = 1'b0; cyc(); startn = 1'b1;
    repeat (10) cyc();
    timer_zero = 1'b1; cyc(); timer_zero = 1'b0;
    repeat (50) cyc();
    checks++;
    if (beep !== 1'b1) begin errors++; $display("FAIL beep_second_run: got %b expected 1", beep); end
    stopn = 1'b0;
    cyc();
    checks++;
    if (beep !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL beep_stop: got beep=%b busy=%b expected 0 0", beep, busy);
    end
    stopn = 1'b1; cyc();
  endtask

  task automatic test_edge_cases();
    startn = 1'b0; stopn = 1'b0;
    cyc();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_stop_same: got busy=%b expected 0", busy); end
    startn = 1'b1; stopn = 1'b1; cyc();
    timer_zero = 1'b1;
    press_start();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_timer_zero: got busy=%b expected 0", busy); end
    timer_zero = 1'b0;
    door_closed = 1'b0;
    press_start();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_door_open: got busy=%b expected 0", busy); end
    door_closed = 1'b1;
    press_start();
    press_key(5);
    checks++;
    if (power_level !== 4'd10 || timer_run !== 1'b1) begin
      errors++; $display("FAIL cook_keypad: got power=%0d run=%b expected 10 1", power_level, timer_run);
    end
    press_power();
    checks++;
    if (timer_run !== 1'b1) begin errors++; $display("FAIL cook_powern: got run=%b expected 1", timer_run); end
    press_stop();
    press_stop();
    press_power();
    keypad = 10'b0000000110; cyc(); keypad = '0; cyc();
    checks++;
    if (power_level !== 4'd10) begin errors++; $display("FAIL non_onehot: got %0d expected 10", power_level); end
    press_key(7);
    checks++;
    if (power_level !== 4'd7 || busy !== 1'b0) begin
      errors++; $display("FAIL power_7: got power=%0d busy=%b expected 7 0", power_level, busy);
    end
    press_power();
    press_stop();
    checks++;
    if (power_level !== 4'd7) begin errors++; $display("FAIL power_set_stop: got %0d expected 7", power_level); end
  endtask

  task automatic test_reset_mid_cook();
    press_start();
    repeat (20) cyc();
    checks++;
    if (timer_run !== 1'b1 || mag_on !== 1'b1) begin
      errors++; $display("FAIL precook_reset: got run=%b mag=%b expected 1 1", timer_run, mag_on);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({timer_run, mag_on, busy, sec_tick, beep} !== 5'b0 || power_level !== 4'd10) begin
      errors++; $display("FAIL async_reset: got outs=%b power=%0d expected 00000 10",
                         {timer_run, mag_on, busy, sec_tick, beep}, power_level);
    end
    cyc();
    rst = 1'b0;
    cyc();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_power_cook();
    test_door_pause();
    test_stop_cancel();
    test_done_beep();
    test_edge_cases();
    test_reset_mid_cook();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
